dma_chan_sched: RTL and testbench

Multi-channel job scheduler that sits between N independent DMA frontends (register or descriptor) and one shared iDMA backend or ND midend. Each channel has its own job FIFO and its own issue/completion transfer-ID counters. A round-robin arbiter feeds jobs to the backend. Backend responses arrive in order and are attributed to the issuing channel through an outstanding-tag FIFO. This generalises the single-stream job FIFO plus ID generator to NumChannels channels, adding per-channel pause and a bound on in-flight jobs.

---
 rtl/dma_chan_sched_if.sv | 38 +++
 rtl/dma_chan_sched.sv | 183 ++++++++++++++++++
 tb/tb_dma_chan_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_chan_sched_if.sv
// Frontend/backend handshake bundle of the multi-channel DMA job scheduler.
// master: the scheduler itself; slave: the frontends plus backend around it.
interface dma_chan_sched_if #(
   parameter int unsigned NumChannels    = 4,
   parameter int unsigned NumOutstanding = 8,
   parameter int unsigned IdCounterWidth = 32,
   parameter type         job_t          = logic
);
   localparam int unsigned ChanIdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam int unsigned OutWidth     = $clog2(NumOutstanding + 1);

   job_t                      chan_req     [NumChannels];
   logic [NumChannels-1:0]    chan_valid;
   logic [NumChannels-1:0]    chan_ready;
   logic [NumChannels-1:0]    chan_enable;
   logic [IdCounterWidth-1:0] chan_next_id [NumChannels];
   logic [IdCounterWidth-1:0] chan_done_id [NumChannels];
   logic [NumChannels-1:0]    chan_busy;
   job_t                      be_req;
   logic [ChanIdxWidth-1:0]   be_chan;
   logic                      be_valid;
   logic                      be_ready;
   logic                      be_rsp_valid;
   logic                      be_rsp_ready;
   logic [OutWidth-1:0]       outstanding;

   modport master (
      input  chan_req, chan_valid, chan_enable, be_ready, be_rsp_valid,
      output chan_ready, chan_next_id, chan_done_id, chan_busy,
             be_req, be_chan, be_valid, be_rsp_ready, outstanding
   );

   modport slave (
      output chan_req, chan_valid, chan_enable, be_ready, be_rsp_valid,
      input  chan_ready, chan_next_id, chan_done_id, chan_busy,
             be_req, be_chan, be_valid, be_rsp_ready, outstanding
   );
endinterface

// File: rtl/dma_chan_sched.sv
// Multi-channel DMA job scheduler: per-channel job FIFOs and ID counters, round-robin
// dispatch to one shared backend, in-order completions attributed through a tag FIFO.
module dma_chan_sched #(
   parameter int unsigned NumChannels    = 4,
   parameter int unsigned JobFifoDepth   = 2,
   parameter int unsigned NumOutstanding = 8,
   parameter int unsigned IdCounterWidth = 32,
   parameter type         job_t          = logic
) (
   input logic              clk_i,
   input logic              rst_ni,
   dma_chan_sched_if.master bus
);
   localparam int unsigned ChanIdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam int unsigned OutWidth     = $clog2(NumOutstanding + 1);
   localparam int unsigned FifoPtrWidth = (JobFifoDepth > 1) ? $clog2(JobFifoDepth) : 1;
   localparam int unsigned FifoCntWidth = $clog2(JobFifoDepth + 1);
   localparam int unsigned TagPtrWidth  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

   typedef logic [ChanIdxWidth-1:0]   chan_idx_t;
   typedef logic [IdCounterWidth-1:0] id_t;
   typedef enum logic {ST_ARB, ST_LOCK} arb_state_e;

   job_t                    fifo_mem_q  [NumChannels][JobFifoDepth];
   logic [FifoPtrWidth-1:0] fifo_wptr_q [NumChannels];
   logic [FifoPtrWidth-1:0] fifo_rptr_q [NumChannels];
   logic [FifoCntWidth-1:0] fifo_cnt_q  [NumChannels];
   chan_idx_t               tag_mem_q   [NumOutstanding];
   logic [TagPtrWidth-1:0]  tag_wptr_q, tag_rptr_q;
   logic [OutWidth-1:0]     out_cnt_q;
   logic [OutWidth-1:0]     inflight_q  [NumChannels];
   id_t                     next_id_q   [NumChannels];
   id_t                     done_id_q   [NumChannels];

   arb_state_e state_q, state_d;
   chan_idx_t  ptr_q, ptr_d, lock_chan_q, lock_chan_d, grant, tag_head;
   logic       grant_vld, be_valid_c, dispatch, retire;
   logic [NumChannels-1:0] full, nonempty, elig, push, pop, retire_chan;

   // Per-channel FIFO status and the accept/pop/retire strobes
   always_comb begin
      tag_head = tag_mem_q[tag_rptr_q];
      retire   = bus.be_rsp_valid & (out_cnt_q != '0);
      for (int unsigned c = 0; c < NumChannels; c++) begin
         full[c]        = (fifo_cnt_q[c] == FifoCntWidth'(JobFifoDepth));
         nonempty[c]    = (fifo_cnt_q[c] != '0);
         elig[c]        = nonempty[c] & bus.chan_enable[c];
         push[c]        = bus.chan_valid[c] & ~full[c];
         pop[c]         = dispatch & (grant == chan_idx_t'(c));
         retire_chan[c] = retire & (tag_head == chan_idx_t'(c));
      end
   end

   // Arbiter: round-robin search, or hold the presented grant while the backend stalls
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_chan_d = lock_chan_q;
      grant       = lock_chan_q;
      grant_vld   = 1'b0;
      if (state_q == ST_LOCK) begin
         grant_vld = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NumChannels; i++) begin
            chan_idx_t idx;
            idx = chan_idx_t'((32'(ptr_q) + NumChannels - 1 - i) % NumChannels);
            if (elig[idx]) begin
               grant     = idx;
               grant_vld = 1'b1;
            end
         end
      end
      be_valid_c = grant_vld & (out_cnt_q < OutWidth'(NumOutstanding));
      dispatch   = be_valid_c & bus.be_ready;
      case (state_q)
         ST_ARB: if (be_valid_c && !bus.be_ready) begin
            state_d     = ST_LOCK;
            lock_chan_d = grant;
         end
         ST_LOCK: if (bus.be_ready) state_d = ST_ARB;
         default: state_d = ST_ARB;
      endcase
      if (dispatch) ptr_d = chan_idx_t'((32'(grant) + 1) % NumChannels);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_ARB;
         ptr_q       <= '0;
         lock_chan_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_chan_q <= lock_chan_d;
      end
   end

   // Job FIFOs, tag FIFO, ID and in-flight counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned c = 0; c < NumChannels; c++) begin
            for (int unsigned d = 0; d < JobFifoDepth; d++) fifo_mem_q[c][d] <= '0;
            fifo_wptr_q[c] <= '0;
            fifo_rptr_q[c] <= '0;
            fifo_cnt_q[c]  <= '0;
            inflight_q[c]  <= '0;
            next_id_q[c]   <= id_t'(1);
            done_id_q[c]   <= '0;
         end
         for (int unsigned t = 0; t < NumOutstanding; t++) tag_mem_q[t] <= '0;
         tag_wptr_q <= '0;
         tag_rptr_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         for (int unsigned c = 0; c < NumChannels; c++) begin
            if (push[c]) begin
               fifo_mem_q[c][fifo_wptr_q[c]] <= bus.chan_req[c];
               fifo_wptr_q[c] <= (fifo_wptr_q[c] == FifoPtrWidth'(JobFifoDepth - 1)) ?
                                 '0 : fifo_wptr_q[c] + 1'b1;
               next_id_q[c]   <= next_id_q[c] + 1'b1;
            end
            if (pop[c]) begin
               fifo_rptr_q[c] <= (fifo_rptr_q[c] == FifoPtrWidth'(JobFifoDepth - 1)) ?
                                 '0 : fifo_rptr_q[c] + 1'b1;
            end
            if (retire_chan[c]) done_id_q[c] <= done_id_q[c] + 1'b1;
            fifo_cnt_q[c] <= fifo_cnt_q[c] + FifoCntWidth'(push[c]) - FifoCntWidth'(pop[c]);
            inflight_q[c] <= inflight_q[c] + OutWidth'(pop[c]) - OutWidth'(retire_chan[c]);
         end
         if (dispatch) begin
            tag_mem_q[tag_wptr_q] <= grant;
            tag_wptr_q <= (tag_wptr_q == TagPtrWidth'(NumOutstanding - 1)) ? '0 : tag_wptr_q + 1'b1;
         end
         if (retire) begin
            tag_rptr_q <= (tag_rptr_q == TagPtrWidth'(NumOutstanding - 1)) ? '0 : tag_rptr_q + 1'b1;
         end
         out_cnt_q <= out_cnt_q + OutWidth'(dispatch) - OutWidth'(retire);
      end
   end

   always_comb begin
      bus.be_valid     = be_valid_c;
      bus.be_req       = be_valid_c ? fifo_mem_q[grant][fifo_rptr_q[grant]] : '0;
      bus.be_chan      = be_valid_c ? grant : '0;
      bus.be_rsp_ready = (out_cnt_q != '0);
      bus.outstanding  = out_cnt_q;
      for (int unsigned c = 0; c < NumChannels; c++) begin
         bus.chan_ready[c]   = ~full[c];
         bus.chan_busy[c]    = nonempty[c] | (inflight_q[c] != '0);
         bus.chan_next_id[c] = next_id_q[c];
         bus.chan_done_id[c] = done_id_q[c];
      end
   end

`ifndef SYNTHESIS
   logic      stall_prev_q;
   job_t      req_prev_q;
   chan_idx_t chan_prev_q;

   // Outstanding bound, stall stability, and accepted - retired == queued + in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_prev_q <= 1'b0;
         req_prev_q   <= '0;
         chan_prev_q  <= '0;
      end else begin
         assert (out_cnt_q <= OutWidth'(NumOutstanding)) else $error("outstanding above bound");
         if (stall_prev_q) begin
            assert (be_valid_c && bus.be_req == req_prev_q && bus.be_chan == chan_prev_q)
               else $error("backend payload changed during stall");
         end
         for (int unsigned c = 0; c < NumChannels; c++) begin
            assert (id_t'(next_id_q[c] - done_id_q[c] - 1'b1) ==
                    id_t'(fifo_cnt_q[c]) + id_t'(inflight_q[c]))
               else $error("done_id overtook next_id");
         end
         stall_prev_q <= be_valid_c & ~bus.be_ready;
         req_prev_q   <= bus.be_req;
         chan_prev_q  <= bus.be_chan;
      end
   end
`endif
endmodule

// File: tb/tb_dma_chan_sched.sv
// Randomised scoreboard bench for dma_chan_sched: per-channel job queues, an in-order
// tag queue and a round-robin rule model predict every output each cycle.
module tb_dma_chan_sched;
   localparam int unsigned N      = 4;
   localparam int unsigned D      = 2;
   localparam int unsigned NO     = 8;
   localparam int unsigned IW     = 4;
   localparam int unsigned IdMask = (1 << IW) - 1;
   typedef logic [15:0] job_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dma_chan_sched_if #(.NumChannels(N), .NumOutstanding(NO), .IdCounterWidth(IW),
                       .job_t(job_t)) bus ();

   dma_chan_sched #(.NumChannels(N), .JobFifoDepth(D), .NumOutstanding(NO),
                    .IdCounterWidth(IW), .job_t(job_t))
      dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   // Reference model state
   job_t        mq [N][$];
   int unsigned m_tag [$];
   int unsigned m_next [N];
   int unsigned m_done [N];
   int unsigned m_ptr, m_lock_chan;
   bit          m_lock, m_seen_zero;
   int unsigned disp_cnt;
   int unsigned disp_log [$];
   int unsigned n_total, n_pass;

   function automatic void check(string name, int unsigned act, int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         mq[c].delete();
         m_next[c] = 1;
         m_done[c] = 0;
      end
      m_tag.delete();
      m_ptr  = 0;
      m_lock = 0;
   endfunction

   // Monitor: predict this cycle's outputs, compare, then commit the observed events
   always @(negedge clk) begin : monitor
      int unsigned exp_chan, idx, t;
      bit found, exp_valid, rsp_ok, in_tag;
      bit exp_ready [N];
      if (!rst_n) begin
         model_reset();
      end else begin
         found = 0;
         exp_chan = 0;
         if (m_lock) begin
            found = 1;
            exp_chan = m_lock_chan;
         end else begin
            for (int i = 0; i < N; i++) begin
               idx = (m_ptr + i) % N;
               if (!found && mq[idx].size() > 0 && bus.chan_enable[idx]) begin
                  found = 1;
                  exp_chan = idx;
               end
            end
         end
         exp_valid = found && (m_tag.size() < NO);
         rsp_ok    = m_tag.size() > 0;
         check("be_valid", bus.be_valid, exp_valid);
         if (exp_valid) begin
            check("be_chan", bus.be_chan, exp_chan);
            check("be_req", bus.be_req, mq[exp_chan][0]);
         end
         check("outstanding", bus.outstanding, m_tag.size());
         check("be_rsp_ready", bus.be_rsp_ready, rsp_ok);
         for (int c = 0; c < N; c++) begin
            exp_ready[c] = mq[c].size() < D;
            in_tag = 0;
            foreach (m_tag[k]) if (m_tag[k] == c) in_tag = 1;
            check($sformatf("chan_ready[%0d]", c), bus.chan_ready[c], exp_ready[c]);
            check($sformatf("chan_busy[%0d]", c), bus.chan_busy[c], (mq[c].size() > 0) || in_tag);
            check($sformatf("next_id[%0d]", c), bus.chan_next_id[c], m_next[c] & IdMask);
            check($sformatf("done_id[%0d]", c), bus.chan_done_id[c], m_done[c] & IdMask);
         end
         if (bus.chan_next_id[0] == '0) m_seen_zero = 1;
         if (exp_valid && bus.be_ready) begin
            void'(mq[exp_chan].pop_front());
            m_tag.push_back(exp_chan);
            m_ptr  = (exp_chan + 1) % N;
            m_lock = 0;
            disp_cnt++;
            disp_log.push_back(bus.be_chan);
         end else if (exp_valid) begin
            m_lock = 1;
            m_lock_chan = exp_chan;
         end
         if (bus.be_rsp_valid && rsp_ok) begin
            t = m_tag.pop_front();
            m_done[t]++;
         end
         for (int c = 0; c < N; c++) begin
            if (bus.chan_valid[c] && exp_ready[c]) begin
               mq[c].push_back(bus.chan_req[c]);
               m_next[c]++;
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.chan_valid   = '0;
      bus.chan_enable  = '1;
      bus.be_ready     = 1'b0;
      bus.be_rsp_valid = 1'b0;
      for (int c = 0; c < N; c++) bus.chan_req[c] = '0;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_chan_ready"}, bus.chan_ready, 4'hF);
      check({tag, "_chan_busy"}, bus.chan_busy, 0);
      check({tag, "_be_valid"}, bus.be_valid, 0);
      check({tag, "_be_req"}, bus.be_req, 0);
      check({tag, "_be_chan"}, bus.be_chan, 0);
      check({tag, "_be_rsp_ready"}, bus.be_rsp_ready, 0);
      check({tag, "_outstanding"}, bus.outstanding, 0);
      for (int c = 0; c < N; c++) begin
         check($sformatf("%s_next_id[%0d]", tag, c), bus.chan_next_id[c], 1);
         check($sformatf("%s_done_id[%0d]", tag, c), bus.chan_done_id[c], 0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
   endtask

   // Offer jobs on the masked channels only when they will be accepted
   task automatic push_jobs(input logic [N-1:0] mask, input int unsigned count);
      int unsigned acc = 0;
      for (int k = 0; k < 200 && acc < count; k++) begin
         @(posedge clk); #1;
         for (int c = 0; c < N; c++) begin
            bus.chan_valid[c] = mask[c] && bus.chan_ready[c] && (acc < count);
            if (bus.chan_valid[c]) begin
               bus.chan_req[c] = job_t'($urandom);
               acc++;
            end
         end
      end
      check("push_count", acc, count);
      @(posedge clk); #1;
      bus.chan_valid = '0;
   endtask

   task automatic drain();
      bit idle = 0;
      bus.chan_valid   = '0;
      bus.chan_enable  = '1;
      bus.be_ready     = 1'b1;
      bus.be_rsp_valid = 1'b1;
      for (int k = 0; k < 300 && !idle; k++) begin
         @(posedge clk); #1;
         idle = (bus.outstanding == 0) && (bus.chan_busy == '0);
      end
      check("drain_idle", idle, 1);
      bus.be_rsp_valid = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      job_t        held;
      int unsigned d0;
      n_total = 0;
      n_pass  = 0;
      disp_cnt = 0;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // Single job on ch2
      bus.be_ready = 1'b1;
      push_jobs(4'b0100, 1);
      check("t1_valid", bus.be_valid, 1);
      check("t1_chan", bus.be_chan, 2);
      check("t1_next_id2", bus.chan_next_id[2], 2);
      @(posedge clk); #1;
      check("t1_outstanding", bus.outstanding, 1);
      check("t1_busy2", bus.chan_busy[2], 1);
      bus.be_rsp_valid = 1'b1;
      @(posedge clk); #1;
      bus.be_rsp_valid = 1'b0;
      check("t1_done_id2", bus.chan_done_id[2], 1);
      check("t1_busy_clear", bus.chan_busy[2], 0);

      // Two jobs per channel, round-robin order from pointer 0
      do_reset();
      push_jobs(4'hF, 8);
      disp_log.delete();
      drain();
      check("t2_disp_count", disp_log.size(), 8);
      for (int i = 0; i < 8 && i < disp_log.size(); i++)
         check($sformatf("t2_order[%0d]", i), disp_log[i], i % N);
      for (int c = 0; c < N; c++)
         check($sformatf("t2_done_id[%0d]", c), bus.chan_done_id[c], 2);

      // Outstanding limit
      do_reset();
      d0 = disp_cnt;
      bus.be_ready = 1'b1;
      push_jobs(4'hF, 12);
      repeat (20) @(posedge clk);
      #1;
      check("t3_dispatched", disp_cnt - d0, 8);
      check("t3_outstanding", bus.outstanding, 8);
      check("t3_valid_low", bus.be_valid, 0);
      bus.be_rsp_valid = 1'b1;
      @(posedge clk); #1;
      bus.be_rsp_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("t3_one_more", disp_cnt - d0, 9);
      check("t3_outstanding_again", bus.outstanding, 8);
      drain();

      // Stall with a competing channel and a pause on the presented one
      bus.be_ready = 1'b0;
      bus.be_rsp_valid = 1'b0;
      push_jobs(4'b0010, 1);
      held = bus.be_req;
      for (int s = 0; s < 5; s++) begin
         check("t4_valid", bus.be_valid, 1);
         check("t4_chan", bus.be_chan, 1);
         check("t4_req", bus.be_req, held);
         if (s == 0) begin
            bus.chan_valid[0] = 1'b1;
            bus.chan_req[0]   = job_t'($urandom);
         end
         if (s == 1) begin
            bus.chan_valid[0]  = 1'b0;
            bus.chan_enable[1] = 1'b0;
         end
         @(posedge clk); #1;
      end
      disp_log.delete();
      bus.be_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t4_disp_count", disp_log.size(), 2);
      if (disp_log.size() >= 2) begin
         check("t4_first", disp_log[0], 1);
         check("t4_second", disp_log[1], 0);
      end
      drain();

      // ID counter wrap on ch0
      do_reset();
      m_seen_zero = 0;
      bus.be_ready = 1'b1;
      bus.be_rsp_valid = 1'b1;
      push_jobs(4'b0001, 16);
      drain();
      check("t5_seen_zero", m_seen_zero, 1);
      check("t5_next_id0", bus.chan_next_id[0], 1);
      check("t5_done_id0", bus.chan_done_id[0], 0);

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk); #1;
         for (int c = 0; c < N; c++) begin
            bus.chan_valid[c]  = $urandom_range(0, 99) < 40;
            bus.chan_req[c]    = job_t'($urandom);
            bus.chan_enable[c] = $urandom_range(0, 99) < 80;
         end
         bus.be_ready     = $urandom_range(0, 99) < 70;
         bus.be_rsp_valid = $urandom_range(0, 99) < 45;
      end
      drain();

      // Reset mid-operation: 3 outstanding, 2 queued
      bus.be_ready = 1'b1;
      bus.be_rsp_valid = 1'b0;
      push_jobs(4'b0111, 3);
      repeat (4) @(posedge clk);
      #1;
      bus.be_ready = 1'b0;
      push_jobs(4'b1000, 2);
      check("t6_outstanding", bus.outstanding, 3);
      check("t6_busy3", bus.chan_busy[3], 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.be_rsp_valid = 1'b1;
      check("t6_rsp_ready", bus.be_rsp_ready, 0);
      @(posedge clk); #1;
      bus.be_rsp_valid = 1'b0;
      check("t6_outstanding_after", bus.outstanding, 0);
      for (int c = 0; c < N; c++)
         check($sformatf("t6_done_id[%0d]", c), bus.chan_done_id[c], 0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
